// File: rtl/pipe_reg_hs.sv
// One-word pipeline register behind a valid/ready handshake, with sync flush and a saturating stall counter.
// Define PIPE_REG_SKID_EN to add a skid entry that gives full throughput with a registered In_Ready.
module pipe_reg_hs #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [WIDTH-1:0] D,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic             Flush,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [1:0]       dbg_state
);

  // Handshake: a word moves on a rising Clk edge when valid and ready are both high.
  // Once Out_Valid is high, Q is held stable until the out-transfer (or a Flush).
`ifdef PIPE_REG_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;
`else
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1} state_t;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nx;
  logic [WIDTH-1:0] q_r;
  logic [CNT_W-1:0] cnt;
  logic             in_xfer, out_xfer, load_d;

`ifdef PIPE_REG_SKID_EN
  logic [WIDTH-1:0] skid_r;
  logic             rdy_r, load_skid, load_from_skid;

  assign In_Ready = rdy_r;
`else
  // Combinational ready: a full register frees up in the same cycle it drains.
  assign In_Ready = !Clr && (!Out_Valid || Out_Ready);
`endif

  assign Out_Valid = (state != EMPTY);
  assign out_xfer  = Out_Valid && Out_Ready;
  assign in_xfer   = In_Valid && In_Ready;
  assign Q         = q_r;
  assign Qn        = ~q_r;
  assign Stall_Cnt = cnt;
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    load_d   = 1'b0;
`ifdef PIPE_REG_SKID_EN
    load_skid      = 1'b0;
    load_from_skid = 1'b0;
`endif
    if (Flush) begin
      state_nx = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            state_nx = FULL;
            load_d   = 1'b1;
          end
        end
        FULL: begin
`ifdef PIPE_REG_SKID_EN
          if (in_xfer && out_xfer) begin
            load_d = 1'b1;
          end else if (in_xfer) begin
            state_nx  = SKID;
            load_skid = 1'b1;
          end else if (out_xfer) begin
            state_nx = EMPTY;
          end
`else
          if (out_xfer) begin
            if (in_xfer) load_d = 1'b1;
            else         state_nx = EMPTY;
          end
`endif
        end
`ifdef PIPE_REG_SKID_EN
        SKID: begin
          if (out_xfer) begin
            state_nx       = FULL;
            load_from_skid = 1'b1;
          end
        end
`endif
        default: state_nx = EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state <= EMPTY;
      q_r   <= RESET_VAL;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (load_d) q_r <= D;
`ifdef PIPE_REG_SKID_EN
      else if (load_from_skid) q_r <= skid_r;
`endif
      // Flush suppresses counting; only Clr clears the counter.
      if (Out_Valid && !Out_Ready && !Flush && cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef PIPE_REG_SKID_EN
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      skid_r <= RESET_VAL;
      rdy_r  <= 1'b0;
    end else begin
      rdy_r <= (state_nx != SKID);
      if (load_skid) skid_r <= D;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Bench for pipe_reg_hs: directed scenarios plus a long random run against a queue-based model.
// Works in both builds (PIPE_REG_SKID_EN defined or not).
module tb_pipe_reg_hs;
  localparam int               W   = 32;
  localparam logic [W-1:0]     RV  = 32'h0000_00A5;
  localparam int               CW  = 2;
  localparam int               SAT = 3;

  logic          clk, clr, in_valid, in_ready, flush, out_valid, out_ready;
  logic [W-1:0]  d, q, qn;
  logic [CW-1:0] stall_cnt;
  logic [1:0]    dbg_state;

  pipe_reg_hs #(.WIDTH(W), .RESET_VAL(RV), .CNT_W(CW)) dut (
    .Clk(clk), .Clr(clr), .D(d), .In_Valid(in_valid), .In_Ready(in_ready),
    .Flush(flush), .Q(q), .Qn(qn), .Out_Valid(out_valid), .Out_Ready(out_ready),
    .Stall_Cnt(stall_cnt), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: the words currently held, in order, plus the last word shown on Q.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_last;
  int           m_stall;
  bit           m_rdy;

  function automatic bit m_ready();
`ifdef PIPE_REG_SKID_EN
    return m_rdy;
`else
    return (exp_q.size() == 0) || out_ready;
`endif
  endfunction

  function automatic void m_reset();
    exp_q.delete();
    m_last  = RV;
    m_stall = 0;
    m_rdy   = 1'b0;
  endfunction

  task automatic drive(input bit iv, input bit ord, input bit fl, input logic [W-1:0] dv);
    in_valid  = iv;
    out_ready = ord;
    flush     = fl;
    d         = dv;
    #2;
  endtask

  task automatic clk_edge(output bit acc);
    bit rdy, ov;
    rdy = m_ready();
    ov  = exp_q.size() > 0;
    @(posedge clk);
    acc = 1'b0;
    if (ov && !out_ready && !flush && m_stall < SAT) m_stall++;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (ov && out_ready) void'(exp_q.pop_front());
      if (in_valid && rdy) begin
        exp_q.push_back(d);
        acc = 1'b1;
      end
    end
    if (exp_q.size() > 0) m_last = exp_q[0];
    m_rdy = exp_q.size() < 2;
    #1;
  endtask

  task automatic do_reset();
    bit a;
    in_valid = 0; out_ready = 0; flush = 0; d = '0;
    clr = 1'b1;
    #2;
    clr = 1'b0;
    m_reset();
    clk_edge(a);
  endtask

  task automatic test_reset();
    bit a;
    do_reset();
    drive(1, 1, 0, 32'h3C);
    clk_edge(a);
    #3 clr = 1'b1;
    #1;
    n_cmp++; if (q !== 32'h0000_00A5) begin n_fail++; $display("FAIL reset_q got=%h exp=%h", q, 32'h0000_00A5); end
    n_cmp++; if (qn !== 32'hFFFF_FF5A) begin n_fail++; $display("FAIL reset_qn got=%h exp=%h", qn, 32'hFFFF_FF5A); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    clr = 1'b0;
    m_reset();
    drive(0, 0, 0, '0);
    clk_edge(a);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_streaming();
    bit a;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 1, 0, W'(i));
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready i=%0d got=%b exp=1", i, in_ready); end
      clk_edge(a);
      n_cmp++; if (q !== W'(i)) begin n_fail++; $display("FAIL stream_q i=%0d got=%h exp=%h", i, q, W'(i)); end
      n_cmp++; if (qn !== ~W'(i)) begin n_fail++; $display("FAIL stream_qn i=%0d got=%h exp=%h", i, qn, ~W'(i)); end
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_out_valid i=%0d got=%b exp=1", i, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] words[3];
    logic [W-1:0] outs[4];
    int idx, n_out;
    bit a, iv, exp_rdy;
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    do_reset();
    idx = 0;
    // First edge lands 0x11, then three stalled edges.
    for (int c = 0; c < 4; c++) begin
      drive(1, 0, 0, words[idx]);
      clk_edge(a);
      if (a) idx++;
      n_cmp++; if (q !== 32'h11) begin n_fail++; $display("FAIL bp_q_hold c=%0d got=%h exp=11", c, q); end
`ifdef PIPE_REG_SKID_EN
      exp_rdy = (c == 0);
`else
      exp_rdy = 1'b0;
`endif
      n_cmp++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL bp_in_ready c=%0d got=%b exp=%b", c, in_ready, exp_rdy); end
    end
    n_cmp++; if (stall_cnt !== CW'(3)) begin n_fail++; $display("FAIL bp_stall got=%0d exp=3", stall_cnt); end
    n_out = 0;
    for (int c = 0; c < 4; c++) begin
      iv = idx < 3;
      drive(iv, 1, 0, iv ? words[idx] : '0);
      if (out_valid === 1'b1) begin outs[n_out] = q; n_out++; end
      clk_edge(a);
      if (a) idx++;
    end
    n_cmp++; if (n_out !== 3) begin n_fail++; $display("FAIL bp_out_count got=%0d exp=3", n_out); end
    for (int k = 0; k < 3 && k < n_out; k++) begin
      n_cmp++; if (outs[k] !== words[k]) begin n_fail++; $display("FAIL bp_order k=%0d got=%h exp=%h", k, outs[k], words[k]); end
    end
  endtask

  task automatic test_flush();
    bit a;
    int stall_exp;
    do_reset();
    drive(1, 0, 0, 32'h77);
    clk_edge(a);
    stall_exp = 0;
`ifdef PIPE_REG_SKID_EN
    drive(1, 0, 0, 32'h88);
    clk_edge(a);
    stall_exp = 1;
`endif
    drive(1, 0, 1, 32'h55);
    clk_edge(a);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (stall_cnt !== CW'(stall_exp)) begin n_fail++; $display("FAIL flush_stall got=%0d exp=%0d", stall_cnt, stall_exp); end
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 0, '0);
      clk_edge(a);
      n_cmp++; if (out_valid !== 1'b0 || q !== 32'h77) begin n_fail++; $display("FAIL flush_drain c=%0d got=%b/%h exp=0/77", c, out_valid, q); end
    end
    // Flush coinciding with an out-transfer.
    drive(1, 1, 0, 32'h99);
    clk_edge(a);
    drive(0, 1, 1, '0);
    clk_edge(a);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_xfer got=%b exp=0", out_valid); end
    drive(1, 1, 0, 32'hAB);
    clk_edge(a);
    n_cmp++; if (q !== 32'hAB || out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_refill got=%h/%b exp=ab/1", q, out_valid); end
  endtask

  task automatic test_saturation();
    int seq[6];
    bit a;
    seq[0] = 1; seq[1] = 2; seq[2] = 3; seq[3] = 3; seq[4] = 3; seq[5] = 3;
    do_reset();
    drive(1, 0, 0, 32'h5A);
    clk_edge(a);
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, '0);
      clk_edge(a);
      n_cmp++; if (stall_cnt !== CW'(seq[k])) begin n_fail++; $display("FAIL sat_stall k=%0d got=%0d exp=%0d", k, stall_cnt, seq[k]); end
    end
    n_cmp++; if (q !== 32'h5A) begin n_fail++; $display("FAIL sat_q got=%h exp=5a", q); end
  endtask

  task automatic test_random();
    bit a, iv, ord, fl;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      iv  = $urandom_range(0, 3) != 0;
      ord = $urandom_range(0, 2) != 0;
      fl  = $urandom_range(0, 31) == 0;
      drive(iv, ord, fl, $urandom);
      n_cmp++; if (in_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, m_ready()); end
      clk_edge(a);
      n_cmp++; if (out_valid !== (exp_q.size() > 0)) begin n_fail++; $display("FAIL rnd_out_valid c=%0d got=%b exp=%b", c, out_valid, exp_q.size() > 0); end
      n_cmp++; if (q !== m_last) begin n_fail++; $display("FAIL rnd_q c=%0d got=%h exp=%h", c, q, m_last); end
      n_cmp++; if (qn !== ~m_last) begin n_fail++; $display("FAIL rnd_qn c=%0d got=%h exp=%h", c, qn, ~m_last); end
      n_cmp++; if (stall_cnt !== CW'(m_stall)) begin n_fail++; $display("FAIL rnd_stall c=%0d got=%0d exp=%0d", c, stall_cnt, m_stall); end
    end
  endtask

  initial begin
    clr = 1'b1; in_valid = 0; out_ready = 0; flush = 0; d = '0;
    m_reset();
    #6;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
